// File: rtl/h264_invdc_dequant.sv
// rtl/h264_invdc_dequant.sv - H.264 chroma DC 2x2 inverse Hadamard and dequantisation
// Collects four DC levels, transforms and scales them in one cycle, then streams them out.
module h264_invdc_dequant #(
  parameter int TOGETHER = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [15:0] ZIN,
  input  logic [5:0]  QP,
  output logic        READYI,
  output logic        VALID,
  output logic [15:0] DCOUT,
  input  logic        READYO
);

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

  state_t             state_q;
  logic [1:0]         k_q;
  logic [1:0]         j_q;
  logic [5:0]         qp_q;
  logic signed [15:0] c_q [4];
  logic signed [15:0] y_q [4];
  logic signed [15:0] y_d [4];
  logic               valid_q;
  logic [15:0]        dcout_q;

  logic [5:0]         qp_clamp;
  logic [2:0]         qmod;
  logic [3:0]         sh;
  logic [4:0]         v;
  logic signed [17:0] e0, e1, e2, e3;
  logic signed [17:0] s0, d0, s1, d1;
  logic signed [17:0] f00, f01, f10, f11;

  // Worst case |f*v<<8| is about 6e8, so 34 bits holds the product without overflow.
  function automatic logic signed [15:0] dequant(input logic signed [17:0] f,
                                                 input logic [4:0] vv,
                                                 input logic [3:0] shift);
    logic signed [33:0] p;
    p = (34'(f) * $signed({29'd0, vv})) <<< shift;
    p = p >>> 1;
    if (p > 34'sd32767)
      return 16'sh7fff;
    else if (p < -34'sd32768)
      return 16'sh8000;
    else
      return p[15:0];
  endfunction

  assign qp_clamp = (QP > 6'd51) ? 6'd51 : QP;
  assign qmod     = 3'(qp_q % 6'd6);
  assign sh       = 4'(qp_q / 6'd6);

  always_comb begin
    case (qmod)
      3'd0:    v = 5'd10;
      3'd1:    v = 5'd11;
      3'd2:    v = 5'd13;
      3'd3:    v = 5'd14;
      3'd4:    v = 5'd16;
      default: v = 5'd18;
    endcase
  end

  always_comb begin
    e0  = 18'(c_q[0]);
    e1  = 18'(c_q[1]);
    e2  = 18'(c_q[2]);
    e3  = 18'(c_q[3]);
    s0  = e0 + e1;
    d0  = e0 - e1;
    s1  = e2 + e3;
    d1  = e2 - e3;
    f00 = s0 + s1;
    f01 = d0 + d1;
    f10 = s0 - s1;
    f11 = d0 - d1;
    y_d[0] = dequant(f00, v, sh);
    y_d[1] = dequant(f01, v, sh);
    y_d[2] = dequant(f10, v, sh);
    y_d[3] = dequant(f11, v, sh);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= LOAD;
      k_q     <= 2'd0;
      j_q     <= 2'd0;
      qp_q    <= 6'd0;
      valid_q <= 1'b0;
      dcout_q <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        c_q[i] <= 16'sd0;
        y_q[i] <= 16'sd0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          valid_q <= 1'b0;
          if (ENABLE) begin
            c_q[k_q] <= ZIN;
            if (k_q == 2'd0)
              qp_q <= qp_clamp;
            k_q <= k_q + 2'd1;
            if (k_q == 2'd3)
              state_q <= CALC;
          end
        end
        CALC: begin
          valid_q <= 1'b0;
          for (int i = 0; i < 4; i++)
            y_q[i] <= y_d[i];
          j_q     <= 2'd0;
          state_q <= OUT;
        end
        OUT: begin
          // With TOGETHER set, only the first coefficient waits for READYO.
          if (READYO || ((TOGETHER != 0) && (j_q != 2'd0))) begin
            valid_q <= 1'b1;
            dcout_q <= y_q[j_q];
            j_q     <= j_q + 2'd1;
            if (j_q == 2'd3) begin
              state_q <= LOAD;
              k_q     <= 2'd0;
            end
          end else begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= LOAD;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign READYI = (state_q == LOAD);
  assign VALID  = valid_q;
  assign DCOUT  = dcout_q;

endmodule

// File: tb/tb_h264_invdc_dequant.sv
// tb/tb_h264_invdc_dequant.sv - directed bench for the chroma DC inverse transform/dequant
// Two instances share stimulus: u_dut0 drains on READYO, u_dut1 drains together.
module tb_h264_invdc_dequant;

  logic        CLK;
  logic        RESET;
  logic        ENABLE;
  logic [15:0] ZIN;
  logic [5:0]  QP;
  logic        READYO;
  logic        readyi0, valid0, readyi1, valid1;
  logic [15:0] dcout0, dcout1;

  int n_run  = 0;
  int n_fail = 0;

  h264_invdc_dequant #(.TOGETHER(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .ZIN(ZIN), .QP(QP),
    .READYI(readyi0), .VALID(valid0), .DCOUT(dcout0), .READYO(READYO)
  );

  h264_invdc_dequant #(.TOGETHER(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .ZIN(ZIN), .QP(QP),
    .READYI(readyi1), .VALID(valid1), .DCOUT(dcout1), .READYO(READYO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Later beats carry the inverted QP so a design that recaptures it gets caught.
  task automatic send_block(input logic [15:0] z0, input logic [15:0] z1,
                            input logic [15:0] z2, input logic [15:0] z3,
                            input logic [5:0] q, input int gap);
    logic [15:0] z [4];
    z[0] = z0; z[1] = z1; z[2] = z2; z[3] = z3;
    for (int i = 0; i < 4; i++) begin
      ENABLE = 1'b1;
      ZIN    = z[i];
      QP     = (i == 0) ? q : ~q;
      tick();
      if (i == 1) begin
        for (int g = 0; g < gap; g++) begin
          ENABLE = 1'b0;
          ZIN    = 16'h1234;
          tick();
        end
      end
    end
    ENABLE = 1'b0;
    ZIN    = 16'h5a5a;
  endtask

  task automatic run_block(input string name,
                           input logic [15:0] z0, input logic [15:0] z1,
                           input logic [15:0] z2, input logic [15:0] z3,
                           input logic [5:0] q, input int gap,
                           input logic signed [15:0] x0, input logic signed [15:0] x1,
                           input logic signed [15:0] x2, input logic signed [15:0] x3);
    logic signed [15:0] x [4];
    x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3;
    READYO = 1'b1;
    send_block(z0, z1, z2, z3, q, gap);
    n_run++;
    if (readyi0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s readyi_calc got %b want 0", name, readyi0);
    end
    tick();
    n_run++;
    if (valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s valid_early got %b want 0", name, valid0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_run++;
      if (valid0 !== 1'b1 || dcout0 !== x[i]) begin
        n_fail++;
        $display("FAIL %s out[%0d] got valid=%b dcout=%0d want valid=1 dcout=%0d",
                 name, i, valid0, $signed(dcout0), x[i]);
      end
      n_run++;
      if (readyi0 !== (i == 3)) begin
        n_fail++;
        $display("FAIL %s readyi[%0d] got %b want %b", name, i, readyi0, (i == 3));
      end
    end
    tick();
    n_run++;
    if (valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s valid_after got %b want 0", name, valid0);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    n_run++;
    if (valid0 !== 1'b0 || dcout0 !== 16'd0 || readyi0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset dut0 got valid=%b dcout=%0d readyi=%b want 0 0 1", valid0, dcout0, readyi0);
    end
    n_run++;
    if (valid1 !== 1'b0 || dcout1 !== 16'd0 || readyi1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset dut1 got valid=%b dcout=%0d readyi=%b want 0 0 1", valid1, dcout1, readyi1);
    end
    RESET = 1'b0;
  endtask

  task automatic test_dc();
    run_block("dc", 16'd4, 16'd0, 16'd0, 16'd0, 6'd0, 0, 16'sd20, 16'sd20, 16'sd20, 16'sd20);
  endtask

  task automatic test_mixed();
    run_block("mixed", 16'd1, 16'd2, 16'd3, 16'd4, 6'd6, 2, 16'sd100, -16'sd20, -16'sd40, 16'sd0);
    run_block("qp5", 16'd3, 16'd1, 16'd0, 16'd0, 6'd5, 1, 16'sd36, 16'sd18, 16'sd36, 16'sd18);
  endtask

  task automatic test_floor();
    run_block("floor_neg", 16'hffff, 16'd0, 16'd0, 16'd0, 6'd1, 0, -16'sd6, -16'sd6, -16'sd6, -16'sd6);
    run_block("qp12", 16'd1, 16'hffff, 16'd0, 16'd0, 6'd12, 0, 16'sd0, 16'sd40, 16'sd0, 16'sd40);
  endtask

  task automatic test_saturation();
    run_block("sat_pos", 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 6'd63, 0,
              16'sd32767, 16'sd0, 16'sd0, 16'sd0);
    run_block("sat_neg", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 6'd51, 0,
              -16'sd32768, 16'sd0, 16'sd0, 16'sd0);
  endtask

  task automatic test_backpressure();
    logic [6:0]         pat;
    logic signed [15:0] x [4];
    int                 idx;
    pat = 7'b1011001;
    x[0] = 16'sd100; x[1] = -16'sd20; x[2] = -16'sd40; x[3] = 16'sd0;
    idx = 0;
    READYO = 1'b0;
    send_block(16'd1, 16'd2, 16'd3, 16'd4, 6'd6, 0);
    tick();
    n_run++;
    if (valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp valid_calc got %b want 0", valid0);
    end
    for (int c = 0; c < 7; c++) begin
      READYO = pat[6 - c];
      ENABLE = (c < 6);
      ZIN    = 16'h7777;
      tick();
      n_run++;
      if (valid0 !== pat[6 - c]) begin
        n_fail++;
        $display("FAIL bp valid[%0d] got %b want %b", c, valid0, pat[6 - c]);
      end
      if (pat[6 - c]) begin
        n_run++;
        if (dcout0 !== x[idx]) begin
          n_fail++;
          $display("FAIL bp dcout[%0d] got %0d want %0d", idx, $signed(dcout0), x[idx]);
        end
        idx++;
      end else if (idx > 0) begin
        n_run++;
        if (dcout0 !== x[idx - 1]) begin
          n_fail++;
          $display("FAIL bp hold[%0d] got %0d want %0d", c, $signed(dcout0), x[idx - 1]);
        end
      end
      n_run++;
      if (readyi0 !== (idx == 4)) begin
        n_fail++;
        $display("FAIL bp readyi[%0d] got %b want %b", c, readyi0, (idx == 4));
      end
    end
    ENABLE = 1'b0;
    READYO = 1'b1;
    tick();
    n_run++;
    if (valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp extra_valid got %b want 0", valid0);
    end
    run_block("after_bp", 16'd4, 16'd0, 16'd0, 16'd0, 6'd0, 0, 16'sd20, 16'sd20, 16'sd20, 16'sd20);
  endtask

  task automatic test_together();
    logic signed [15:0] x [4];
    x[0] = 16'sd100; x[1] = -16'sd20; x[2] = -16'sd40; x[3] = 16'sd0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    READYO = 1'b0;
    send_block(16'd1, 16'd2, 16'd3, 16'd4, 6'd6, 0);
    tick();
    for (int c = 0; c < 4; c++) begin
      READYO = (c == 0);
      tick();
      n_run++;
      if (valid1 !== 1'b1 || dcout1 !== x[c]) begin
        n_fail++;
        $display("FAIL together out[%0d] got valid=%b dcout=%0d want valid=1 dcout=%0d",
                 c, valid1, $signed(dcout1), x[c]);
      end
      if (c == 1) begin
        n_run++;
        if (valid0 !== 1'b0) begin
          n_fail++;
          $display("FAIL together dut0_stall got %b want 0", valid0);
        end
      end
    end
    n_run++;
    if (readyi1 !== 1'b1) begin
      n_fail++;
      $display("FAIL together readyi got %b want 1", readyi1);
    end
    tick();
    n_run++;
    if (valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL together valid_after got %b want 0", valid1);
    end
  endtask

  task automatic test_reset_mid();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    READYO = 1'b1;
    send_block(16'd1, 16'd2, 16'd3, 16'd4, 6'd6, 0);
    tick();
    tick();
    tick();
    n_run++;
    if (valid0 !== 1'b1 || dcout0 !== 16'hffec) begin
      n_fail++;
      $display("FAIL rstmid second got valid=%b dcout=%0d want valid=1 dcout=-20", valid0, $signed(dcout0));
    end
    RESET = 1'b1;
    ENABLE = 1'b1;
    ZIN = 16'd9;
    tick();
    n_run++;
    if (valid0 !== 1'b0 || dcout0 !== 16'd0 || readyi0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid state got valid=%b dcout=%0d readyi=%b want 0 0 1", valid0, dcout0, readyi0);
    end
    RESET = 1'b0;
    ZIN = 16'd7;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    ENABLE = 1'b0;
    run_block("post_reset", 16'd4, 16'd0, 16'd0, 16'd0, 6'd0, 0, 16'sd20, 16'sd20, 16'sd20, 16'sd20);
  endtask

  initial begin
    RESET  = 1'b1;
    ENABLE = 1'b0;
    ZIN    = 16'd0;
    QP     = 6'd0;
    READYO = 1'b0;
    test_reset();
    test_dc();
    test_mixed();
    test_floor();
    test_saturation();
    test_backpressure();
    test_together();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
